// File: rtl/m_stage_mem_ctrl.sv
// m_stage_mem_ctrl -- memory stage of the five-stage MIPS pipeline.
// Holds the E->M pipeline register, decodes the held instruction for
// forwarding and write-back, drives a req/ack data-memory port with byte,
// halfword and word accesses, and raises AdEL/AdES/DBE exceptions.
// Optional feature: define M_CTRL_TIMEOUT_EN to compile in the bus watchdog
// that turns a missing dm_ack into a DBE exception after TIMEOUT_CYC waits.
module m_stage_mem_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        e_valid,
  input  logic [31:0] e_instr,
  input  logic [31:0] e_alu,
  input  logic [31:0] e_rt_data,
  output logic        m_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] m_load_data,
  output logic [1:0]  m_t_new,
  output logic [4:0]  m_wreg,
  output logic [1:0]  s_m_grf_wdata,
  output logic        m_grf_we,
  output logic        m_exc,
  output logic [4:0]  m_exc_code
);

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  // The watchdog needs at least two wait cycles and a counter wide enough
  // to hold TIMEOUT_CYC.
  if (TIMEOUT_CYC < 2 || CNT_W < $clog2(TIMEOUT_CYC + 1)) begin : g_bad_param
    $error("m_stage_mem_ctrl: TIMEOUT_CYC must be >= 2 and CNT_W wide enough");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rt_q, rt_d;

  // Stage register advances whenever M is not stalled; a bubble becomes a nop.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    valid_d = valid_q;
    instr_d = instr_q;
    alu_d   = alu_q;
    rt_d    = rt_q;
    if (!m_stall) begin
      valid_d = e_valid;
      instr_d = e_valid ? e_instr : 32'd0;
      alu_d   = e_alu;
      rt_d    = e_rt_data;
    end
  end

  // Pipeline register and FSM state; reset parks a nop in M.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!reset_n) begin
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      alu_q   <= 32'd0;
      rt_q    <= 32'd0;
      state_q <= S_IDLE;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      alu_q   <= alu_d;
      rt_q    <= rt_d;
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- decode
  logic [5:0] opcode, funct;
  logic [4:0] rt_idx, rd_idx;
  logic       is_rarith, is_imm, is_jal, is_load, is_store;
  logic       acc_byte, acc_half, acc_word, ld_signed;
  logic       unused_bits;

  assign opcode      = instr_q[31:26];
  assign rt_idx      = instr_q[20:16];
  assign rd_idx      = instr_q[15:11];
  assign funct       = instr_q[5:0];
  assign unused_bits = ^{instr_q[25:21], instr_q[10:6]};

  // Classify the held instruction; unknown opcodes, beq and jr do nothing here.
  always_comb begin
    is_rarith = 1'b0;
    is_imm    = 1'b0;
    is_jal    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    acc_byte  = 1'b0;
    acc_half  = 1'b0;
    acc_word  = 1'b0;
    ld_signed = 1'b0;
    if (valid_q) begin
      case (opcode)
        6'b000000: is_rarith = (funct == 6'b100000) || (funct == 6'b100010);
        6'b001101,
        6'b001111: is_imm = 1'b1;
        6'b000011: is_jal = 1'b1;
        6'b100011: begin is_load = 1'b1; acc_word = 1'b1; end
        6'b100000: begin is_load = 1'b1; acc_byte = 1'b1; ld_signed = 1'b1; end
        6'b100100: begin is_load = 1'b1; acc_byte = 1'b1; end
        6'b100001: begin is_load = 1'b1; acc_half = 1'b1; ld_signed = 1'b1; end
        6'b100101: begin is_load = 1'b1; acc_half = 1'b1; end
        6'b101011: begin is_store = 1'b1; acc_word = 1'b1; end
        6'b101000: begin is_store = 1'b1; acc_byte = 1'b1; end
        6'b101001: begin is_store = 1'b1; acc_half = 1'b1; end
        default: ;
      endcase
    end
  end

  logic misalign, mem_ok, timeout, fault;

  assign misalign = (acc_half & alu_q[0]) | (acc_word & (|alu_q[1:0]));
  assign mem_ok   = (is_load | is_store) & ~misalign;

  // --------------------------------------------------------------- watchdog
`ifdef M_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count WAIT cycles; any other state clears the count.
  always_comb begin
    cnt_d = (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign timeout = (state_q == S_WAIT) && (cnt_q == LAST_WAIT);
`else
  assign timeout = 1'b0;
`endif

  // Access FSM: request, stall until ack, optionally fault on timeout.
  always_comb begin
    state_d = state_q;
    dm_req  = 1'b0;
    m_stall = 1'b0;
    fault   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_ok) begin
          dm_req = 1'b1;
          if (!dm_ack) begin
            m_stall = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        dm_req = 1'b1;
        if (dm_ack) begin
          state_d = S_IDLE;
        end else begin
          m_stall = 1'b1;
          if (timeout) state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        fault   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------ memory port
  assign dm_we   = dm_req & is_store;
  assign dm_addr = {alu_q[31:2], 2'b00};

  // Byte enables and lane-replicated store data for the current access.
  always_comb begin
    dm_be    = 4'b0000;
    dm_wdata = 32'd0;
    if (dm_req) begin
      if (acc_byte && is_store) dm_be = 4'b0001 << alu_q[1:0];
      else if (acc_half && is_store) dm_be = alu_q[1] ? 4'b1100 : 4'b0011;
      else dm_be = 4'b1111;
    end
    if (is_store) begin
      if (acc_byte)      dm_wdata = {4{rt_q[7:0]}};
      else if (acc_half) dm_wdata = {2{rt_q[15:0]}};
      else               dm_wdata = rt_q;
    end
  end

  // Pick the addressed lane of the read word and extend it.
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  always_comb begin
    lane_b      = dm_rdata[{alu_q[1:0], 3'b000} +: 8];
    lane_h      = alu_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    m_load_data = 32'd0;
    if (is_load) begin
      if (acc_word)      m_load_data = dm_rdata;
      else if (acc_half) m_load_data = {{16{ld_signed & lane_h[15]}}, lane_h};
      else               m_load_data = {{24{ld_signed & lane_b[7]}}, lane_b};
    end
  end

  // ------------------------------------------------- exceptions, write-back
  assign m_exc = misalign | fault;

  // Timeout takes precedence; it only occurs on aligned accesses anyway.
  always_comb begin
    m_exc_code = 5'd0;
    if (fault)         m_exc_code = EXC_DBE;
    else if (misalign) m_exc_code = is_load ? EXC_ADEL : EXC_ADES;
  end

  // Destination register, result source and write enable for forwarding/W.
  always_comb begin
    m_wreg        = 5'd0;
    s_m_grf_wdata = 2'b00;
    if (is_rarith)               m_wreg = rd_idx;
    else if (is_imm || is_load)  m_wreg = rt_idx;
    else if (is_jal)             m_wreg = 5'd31;
    if (is_load)     s_m_grf_wdata = 2'b01;
    else if (is_jal) s_m_grf_wdata = 2'b10;
  end

  assign m_t_new  = {1'b0, is_load};
  assign m_grf_we = (is_rarith | is_imm | is_jal | is_load) & ~m_exc;

endmodule

// File: tb/tb_m_stage_mem_ctrl.sv
// tb_m_stage_mem_ctrl -- self-checking bench for m_stage_mem_ctrl.
// Instructions are described by kind; expected port values come from a
// transaction-level model (access size, lane offset, wait count).
module tb_m_stage_mem_ctrl;

  localparam int TO = 4;

  logic        clk, reset_n;
  logic        e_valid;
  logic [31:0] e_instr, e_alu, e_rt_data;
  logic        m_stall, dm_req, dm_we, dm_ack;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, m_load_data;
  logic [1:0]  m_t_new, s_m_grf_wdata;
  logic [4:0]  m_wreg, m_exc_code;
  logic        m_grf_we, m_exc;

  int n_vec = 0;
  int n_err = 0;

  m_stage_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .e_valid(e_valid), .e_instr(e_instr), .e_alu(e_alu), .e_rt_data(e_rt_data),
    .m_stall(m_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .m_load_data(m_load_data), .m_t_new(m_t_new), .m_wreg(m_wreg),
    .s_m_grf_wdata(s_m_grf_wdata), .m_grf_we(m_grf_we),
    .m_exc(m_exc), .m_exc_code(m_exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    K_ADD, K_SUB, K_JR, K_ORI, K_LUI, K_BEQ, K_JAL, K_LW,
    K_LB, K_LBU, K_LH, K_LHU, K_SW, K_SB, K_SH, K_NOP
  } kind_e;

  typedef struct {
    int         size;   // access bytes, 0 for non-memory
    bit         load;
    bit         store;
    bit         sext;
    bit         wr;
    logic [4:0] wreg;
    logic [1:0] sel;
  } desc_t;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input kind_e k, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm);
    case (k)
      K_ADD:   return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      K_SUB:   return {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
      K_JR:    return {6'b000000, rs, 5'd0, rd, 5'd0, 6'b001000};
      K_ORI:   return {6'b001101, rs, rt, imm};
      K_LUI:   return {6'b001111, 5'd0, rt, imm};
      K_BEQ:   return {6'b000100, rs, rt, imm};
      K_JAL:   return {6'b000011, rs, rt, imm};
      K_LW:    return {6'b100011, rs, rt, imm};
      K_LB:    return {6'b100000, rs, rt, imm};
      K_LBU:   return {6'b100100, rs, rt, imm};
      K_LH:    return {6'b100001, rs, rt, imm};
      K_LHU:   return {6'b100101, rs, rt, imm};
      K_SW:    return {6'b101011, rs, rt, imm};
      K_SB:    return {6'b101000, rs, rt, imm};
      K_SH:    return {6'b101001, rs, rt, imm};
      default: return 32'd0;
    endcase
  endfunction

  function automatic desc_t describe(input kind_e k, input logic [4:0] rt, input logic [4:0] rd);
    desc_t d;
    d.size = 0; d.load = 0; d.store = 0; d.sext = 0; d.wr = 0; d.wreg = 5'd0; d.sel = 2'd0;
    case (k)
      K_ADD, K_SUB: begin d.wr = 1; d.wreg = rd; end
      K_ORI, K_LUI: begin d.wr = 1; d.wreg = rt; end
      K_JAL:        begin d.wr = 1; d.wreg = 5'd31; d.sel = 2'd2; end
      K_LW:         begin d.load = 1; d.size = 4; end
      K_LB:         begin d.load = 1; d.size = 1; d.sext = 1; end
      K_LBU:        begin d.load = 1; d.size = 1; end
      K_LH:         begin d.load = 1; d.size = 2; d.sext = 1; end
      K_LHU:        begin d.load = 1; d.size = 2; end
      K_SW:         begin d.store = 1; d.size = 4; end
      K_SB:         begin d.store = 1; d.size = 1; end
      K_SH:         begin d.store = 1; d.size = 2; end
      default: ;
    endcase
    if (d.load) begin d.wr = 1; d.wreg = rt; d.sel = 2'd1; end
    return d;
  endfunction

  function automatic logic [31:0] lane_mask(input int size);
    return (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
  endfunction

  task automatic bubble();
    e_valid   = 1'b0;
    e_instr   = $urandom;
    e_alu     = $urandom;
    e_rt_data = $urandom;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"},   dm_req, 0);
    check({tag, "_we"},    dm_we, 0);
    check({tag, "_stall"}, m_stall, 0);
    check({tag, "_gwe"},   m_grf_we, 0);
    check({tag, "_exc"},   m_exc, 0);
    check({tag, "_code"},  m_exc_code, 0);
    check({tag, "_be"},    dm_be, 0);
    check({tag, "_addr"},  dm_addr, 0);
    check({tag, "_wdata"}, dm_wdata, 0);
    check({tag, "_ld"},    m_load_data, 0);
    check({tag, "_tnew"},  m_t_new, 0);
    check({tag, "_wreg"},  m_wreg, 0);
    check({tag, "_sel"},   s_m_grf_wdata, 0);
  endtask

  // Present one instruction in E while M holds a nop (ack there must be ignored).
  task automatic present(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] rt_val);
    @(posedge clk); #1;
    e_valid   = 1'b1;
    e_instr   = instr;
    e_alu     = alu;
    e_rt_data = rt_val;
    dm_ack    = 1'($urandom);
    dm_rdata  = $urandom;
    #1;
    check("bubble_req", dm_req, 0);
    check("bubble_stall", m_stall, 0);
  endtask

  // Run one instruction through M; the ack arrives n_wait cycles after the first request.
  task automatic run_op(input kind_e k, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rt_val,
                        input logic [31:0] rdata, input int n_wait);
    desc_t       d;
    bit          mem, mis;
    int          off;
    logic [31:0] mask, exp_wd, exp_ld;
    logic [3:0]  exp_be;
    logic [4:0]  exp_code;
    d    = describe(k, rt, rd);
    mem  = d.load || d.store;
    off  = int'(alu[1:0]);
    mis  = 0;
    mask = 32'd0;
    if (mem) begin
      mis  = (off % d.size) != 0;
      mask = lane_mask(d.size);
    end
    exp_be = d.store ? 4'(((1 << d.size) - 1) << off) : 4'hF;
    exp_wd = 32'd0;
    if (d.store)
      for (int i = 0; i < 4 / d.size; i++) exp_wd |= (rt_val & mask) << (8 * d.size * i);
    exp_code = mis ? (d.load ? 5'd4 : 5'd5) : 5'd0;

    present(encode(k, 5'($urandom), rt, rd, 16'($urandom)), alu, rt_val);

    if (!mem || mis) begin
      @(posedge clk); #1;
      bubble();
      dm_ack   = 1'($urandom);
      dm_rdata = $urandom;
      #1;
      check("op_req", dm_req, 0);
      check("op_stall", m_stall, 0);
      check("op_exc", m_exc, 32'(mis));
      check("op_code", m_exc_code, exp_code);
      check("op_gwe", m_grf_we, 32'(d.wr && !mis));
      check("op_wreg", m_wreg, d.wreg);
      check("op_tnew", m_t_new, 32'(d.load));
      check("op_sel", s_m_grf_wdata, d.sel);
    end else begin
      for (int c = 0; c <= n_wait; c++) begin
        @(posedge clk); #1;
        bubble();
        dm_ack   = (c == n_wait);
        dm_rdata = (c == n_wait) ? rdata : $urandom;
        #1;
        check("mem_req", dm_req, 1);
        check("mem_stall", m_stall, 32'(c < n_wait));
        check("mem_we", dm_we, 32'(d.store));
        check("mem_be", dm_be, exp_be);
        check("mem_addr", dm_addr, {alu[31:2], 2'b00});
        if (d.store) check("mem_wdata", dm_wdata, exp_wd);
        if (c == n_wait) begin
          check("mem_exc", m_exc, 0);
          check("mem_gwe", m_grf_we, 32'(d.wr));
          check("mem_wreg", m_wreg, d.wreg);
          check("mem_tnew", m_t_new, 32'(d.load));
          check("mem_sel", s_m_grf_wdata, d.sel);
          if (d.load) begin
            exp_ld = (rdata >> (8 * off)) & mask;
            if (d.sext && exp_ld[8 * d.size - 1]) exp_ld |= ~mask;
            check("mem_ld", m_load_data, exp_ld);
          end
        end
      end
    end
  endtask

  // lw whose ack never arrives on time.
  task automatic stuck_load();
    present(encode(K_LW, 5'd1, 5'd6, 5'd0, 16'd0), 32'h0000_0240, 32'd0);
    for (int c = 0; c <= TO; c++) begin
      @(posedge clk); #1;
      bubble();
      dm_ack = 1'b0;
      #1;
      check("to_req", dm_req, 1);
      check("to_stall", m_stall, 1);
    end
`ifdef M_CTRL_TIMEOUT_EN
    @(posedge clk); #1;
    bubble();
    dm_ack = 1'b1;
    #1;
    check("to_fault_req", dm_req, 0);
    check("to_fault_stall", m_stall, 0);
    check("to_fault_exc", m_exc, 1);
    check("to_fault_code", m_exc_code, 7);
    check("to_fault_gwe", m_grf_we, 0);
`else
    for (int c = TO + 1; c < 20; c++) begin
      @(posedge clk); #1;
      bubble();
      dm_ack = 1'b0;
      #1;
      check("hold_stall", m_stall, 1);
      check("hold_exc", m_exc, 0);
    end
    @(posedge clk); #1;
    bubble();
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    #1;
    check("hold_ack_stall", m_stall, 0);
    check("hold_ack_ld", m_load_data, 32'hCAFE_F00D);
    check("hold_ack_gwe", m_grf_we, 1);
`endif
  endtask

  // Asynchronous reset while a load is waiting for its ack.
  task automatic reset_in_wait();
    present(encode(K_LW, 5'd2, 5'd8, 5'd0, 16'd0), 32'h0000_0300, 32'h1111_2222);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      bubble();
      dm_ack   = 1'b0;
      dm_rdata = 32'hA5A5_5A5A;
      #1;
      check("rw_stall", m_stall, 1);
    end
    #1 reset_n = 1'b0;
    #1 check_quiet("rst_wait");
    @(posedge clk); #1;
    check_quiet("rst_wait_edge");
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    e_valid   = 1'b0;
    e_instr   = 32'd0;
    e_alu     = 32'd0;
    e_rt_data = 32'd0;
    dm_ack    = 1'b0;
    dm_rdata  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1 check_quiet("reset");
    reset_n = 1'b1;

    run_op(K_LW,  5'd9,  5'd0, 32'h0000_0100, $urandom,      $urandom,      3);
    run_op(K_LB,  5'd10, 5'd0, 32'h0000_0103, 32'd0,         32'h8012_3456, 0);
    run_op(K_LBU, 5'd11, 5'd0, 32'h0000_0103, 32'd0,         32'h8065_4321, 1);
    run_op(K_SH,  5'd12, 5'd0, 32'h0000_0102, 32'h1234_ABCD, 32'd0,         0);
    run_op(K_LH,  5'd13, 5'd0, 32'h0000_0101, 32'd0,         32'd0,         0);
    run_op(K_SW,  5'd14, 5'd0, 32'h0000_0102, 32'h5555_AAAA, 32'd0,         0);
    run_op(K_LHU, 5'd15, 5'd0, 32'h0000_0106, 32'd0,         32'hF00F_1234, TO);
    run_op(K_SB,  5'd16, 5'd0, 32'h0000_0101, 32'h0000_00C3, 32'd0,         2);
    run_op(K_ADD, 5'd3,  5'd17, 32'd0, 32'd0, 32'd0, 0);
    run_op(K_JAL, 5'd3,  5'd17, 32'd0, 32'd0, 32'd0, 0);
    run_op(K_JR,  5'd3,  5'd17, 32'd0, 32'd0, 32'd0, 0);
    run_op(K_ORI, 5'd18, 5'd4,  32'd0, 32'd0, 32'd0, 0);

    stuck_load();
    run_op(K_LW, 5'd20, 5'd0, 32'h0000_0400, 32'd0, 32'h0BAD_F00D, 0);
    reset_in_wait();
    run_op(K_LH, 5'd21, 5'd0, 32'h0000_0402, 32'd0, 32'h8001_7FFF, 1);

    for (int n = 0; n < 120; n++) begin
      kind_e       k;
      logic [31:0] alu;
      k   = kind_e'($urandom_range(0, 15));
      alu = $urandom;
      if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
      run_op(k, 5'($urandom), 5'($urandom), alu, $urandom, $urandom, $urandom_range(0, TO));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
